// File: rtl/result_spike_tx.sv
// result_spike_tx
// Egress node of the SNN NoC. Partial-sum packets from the local/down router
// port are accumulated into one saturating membrane potential per output
// neuron. An end-of-timestep packet starts a readout. The readout thresholds
// every neuron against THRE and streams the spike map to the host, framed as
// [start] header spike*N [done].
//
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   in_valid/ready  packet handshake (ready only while accumulating)
//   in_pkt          [31:30] type, [29:28] timestep, [27:18] neuron addr,
//                   [WIDTH_DATA-1:0] signed partial sum
//   out_valid/ready output beat handshake
//   out_type        0 start, 1 header, 2 spike, 3 done
//   out_ts/layer    timestep and layer (header beats)
//   out_addr/spike  neuron address and spike bit (spike beats)
//   err             sticky: bad neuron address or timestep tag mismatch
//
// Build option
//   RESULT_SOFT_RESET_EN  when defined, a firing neuron has THRE subtracted
//                         (residue carries over); otherwise it is zeroed.
module result_spike_tx #(
  parameter int WIDTH_PKT  = 32,
  parameter int WIDTH_DATA = 13,
  parameter int DEPTH_R    = 21,
  parameter int THRE       = 64,
  parameter int NUM_TS     = 2,
  parameter int LAYER      = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_PKT-1:0] in_pkt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_type,
  output logic [1:0]           out_ts,
  output logic [1:0]           out_layer,
  output logic [9:0]           out_addr,
  output logic                 out_spike,
  output logic                 err
);

  localparam int NEUR  = DEPTH_R * DEPTH_R;
  localparam int AW    = (NEUR > 1) ? $clog2(NEUR) : 1;
  localparam int POT_W = WIDTH_DATA + 2;
  localparam logic signed [POT_W-1:0] THRE_S = POT_W'(THRE);

  typedef enum logic [2:0] {ACCUM, START, HDR, SCAN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [AW-1:0]           idx, idx_nxt;
  logic [1:0]              ts_cnt, ts_nxt;
  logic signed [POT_W-1:0] pot [NEUR];

  logic                    acc_we, fire_we, clear_all, err_set;
  logic [1:0]              beat_type;
  logic                    spike_nxt;
  logic signed [POT_W-1:0] acc_sum, fire_val;

  // Packet fields
  logic [1:0]                   pkt_type, pkt_ts;
  logic [9:0]                   pkt_addr;
  logic [AW-1:0]                pkt_idx;
  logic signed [WIDTH_DATA-1:0] pkt_psum;
  logic                         addr_ok;
  logic                         unused_pkt;

  assign pkt_type   = in_pkt[31:30];
  assign pkt_ts     = in_pkt[29:28];
  assign pkt_addr   = in_pkt[27:18];
  assign pkt_idx    = in_pkt[18 +: AW];
  assign pkt_psum   = in_pkt[WIDTH_DATA-1:0];
  assign addr_ok    = ({1'b0, pkt_addr} < 11'(NEUR));
  assign unused_pkt = &{1'b0, in_pkt};

  // Signed add of a partial sum onto a potential, clamped to the potential range.
  function automatic logic signed [POT_W-1:0] sat_add(
    input logic signed [POT_W-1:0]      a,
    input logic signed [WIDTH_DATA-1:0] b
  );
    logic signed [POT_W:0] s;
    s = $signed({a[POT_W-1], a}) +
        $signed({{(POT_W+1-WIDTH_DATA){b[WIDTH_DATA-1]}}, b});
    if (s[POT_W] != s[POT_W-1])
      sat_add = s[POT_W] ? {1'b1, {(POT_W-1){1'b0}}} : {1'b0, {(POT_W-1){1'b1}}};
    else
      sat_add = s[POT_W-1:0];
  endfunction

  function automatic logic fires(input logic signed [POT_W-1:0] p);
    return (p >= THRE_S);
  endfunction

  assign in_ready = (state == ACCUM);
  assign acc_sum  = sat_add(pot[pkt_idx], pkt_psum);

  // The beat being offered is already registered on out_*; only the potential
  // at idx can change, and only on its own handshake, so a stalled beat stays
  // stable and its firing decision can be taken from out_spike.
  always_comb begin
`ifdef RESULT_SOFT_RESET_EN
    fire_val = pot[idx] - THRE_S;
`else
    fire_val = '0;
`endif
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    ts_nxt    = ts_cnt;
    acc_we    = 1'b0;
    fire_we   = 1'b0;
    clear_all = 1'b0;
    err_set   = 1'b0;
    case (state)
      ACCUM: begin
        if (in_valid) begin
          if (pkt_type == 2'b10) begin
            if (addr_ok) acc_we  = 1'b1;
            else         err_set = 1'b1;
          end else if (pkt_type == 2'b11) begin
            if (pkt_ts != ts_cnt) err_set = 1'b1;
            state_nxt = (ts_cnt == 2'd1) ? START : HDR;
          end
        end
      end
      START: if (out_ready) state_nxt = HDR;
      HDR: begin
        if (out_ready) begin
          state_nxt = SCAN;
          idx_nxt   = '0;
        end
      end
      SCAN: begin
        if (out_ready) begin
          fire_we = out_spike;
          if (idx == AW'(NEUR - 1)) begin
            if (ts_cnt == 2'(NUM_TS)) begin
              state_nxt = DONE;
            end else begin
              ts_nxt    = ts_cnt + 2'd1;
              state_nxt = ACCUM;
            end
          end else begin
            idx_nxt = idx + AW'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          clear_all = 1'b1;
          ts_nxt    = 2'd1;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase

    case (state_nxt)
      HDR:     beat_type = 2'd1;
      SCAN:    beat_type = 2'd2;
      DONE:    beat_type = 2'd3;
      default: beat_type = 2'd0;
    endcase
    spike_nxt = (state_nxt == SCAN) && fires(pot[idx_nxt]);
  end

  // Control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ACCUM;
      idx    <= '0;
      ts_cnt <= 2'd1;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      ts_cnt <= ts_nxt;
      if (err_set) err <= 1'b1;
    end
  end

  // Output beat register: loaded with the beat of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_type  <= 2'd0;
      out_ts    <= 2'd0;
      out_layer <= 2'd0;
      out_addr  <= 10'd0;
      out_spike <= 1'b0;
    end else begin
      out_valid <= (state_nxt != ACCUM);
      out_type  <= beat_type;
      out_ts    <= (state_nxt == HDR)  ? ts_nxt      : 2'd0;
      out_layer <= (state_nxt == HDR)  ? 2'(LAYER)   : 2'd0;
      out_addr  <= (state_nxt == SCAN) ? 10'(idx_nxt) : 10'd0;
      out_spike <= spike_nxt;
    end
  end

  // Membrane potentials: single-cycle read-modify-write, so back-to-back
  // packets to one neuron need no forwarding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NEUR; i++) pot[i] <= '0;
    end else if (clear_all) begin
      for (int i = 0; i < NEUR; i++) pot[i] <= '0;
    end else if (acc_we) begin
      pot[pkt_idx] <= acc_sum;
    end else if (fire_we) begin
      pot[idx] <= fire_val;
    end
  end

endmodule

// File: tb/tb_result_spike_tx.sv
// Bench for result_spike_tx (DEPTH_R=3, THRE=64, NUM_TS=2, LAYER=1).
module tb_result_spike_tx;

  localparam int DR   = 3;
  localparam int TH   = 64;
  localparam int NT   = 2;
  localparam int LY   = 1;
  localparam int WD   = 13;
  localparam int N    = DR * DR;
  localparam int PMAX = (1 << (WD + 1)) - 1;
  localparam int PMIN = -(1 << (WD + 1));
`ifdef RESULT_SOFT_RESET_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pkt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_type, out_ts, out_layer;
  logic [9:0]  out_addr;
  logic        out_spike;
  logic        err;

  result_spike_tx #(
    .WIDTH_PKT(32), .WIDTH_DATA(WD), .DEPTH_R(DR),
    .THRE(TH), .NUM_TS(NT), .LAYER(LY)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_type(out_type), .out_ts(out_ts), .out_layer(out_layer),
    .out_addr(out_addr), .out_spike(out_spike), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int typ;
    int ts;
    int layer;
    int addr;
    int spk;
  } beat_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          m_pot [N];
  int          m_ts;
  bit          m_err;
  beat_t       exp_q [$];
  logic [N-1:0] obs_spk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampv(input int v);
    if (v > PMAX) return PMAX;
    if (v < PMIN) return PMIN;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_pot[i] = 0;
    m_ts  = 1;
    m_err = 1'b0;
    exp_q.delete();
  endtask

  // Expected readout of one timestep, straight from the threshold rules.
  task automatic model_eot(input int tag);
    beat_t b;
    if (tag != m_ts) m_err = 1'b1;
    if (m_ts == 1) begin
      b = '{0, 0, 0, 0, 0};
      exp_q.push_back(b);
    end
    b = '{1, m_ts, LY, 0, 0};
    exp_q.push_back(b);
    for (int i = 0; i < N; i++) begin
      b = '{2, 0, 0, i, (m_pot[i] >= TH) ? 1 : 0};
      exp_q.push_back(b);
      if (m_pot[i] >= TH) m_pot[i] = SOFT ? m_pot[i] - TH : 0;
    end
    if (m_ts == NT) begin
      b = '{3, 0, 0, 0, 0};
      exp_q.push_back(b);
      for (int i = 0; i < N; i++) m_pot[i] = 0;
      m_ts = 1;
    end else begin
      m_ts = m_ts + 1;
    end
  endtask

  function automatic logic [31:0] mk(input int t, input int ts, input int addr, input int val);
    logic [31:0] p;
    p = $urandom;
    p[31:30]  = t[1:0];
    p[29:28]  = ts[1:0];
    p[27:18]  = addr[9:0];
    p[WD-1:0] = val[WD-1:0];
    return p;
  endfunction

  task automatic send(input logic [31:0] p);
    int a, v;
    in_valid = 1'b1;
    in_pkt   = p;
    chk("in_ready_accum", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = p[27:18];
    v = $signed(p[WD-1:0]);
    if (p[31:30] == 2'b10) begin
      if (a >= N) m_err = 1'b1;
      else        m_pot[a] = clampv(m_pot[a] + v);
    end else if (p[31:30] == 2'b11) begin
      model_eot(p[29:28]);
    end
  endtask

  task automatic psum(input int addr, input int val);
    send(mk(2, $urandom_range(0, 3), addr, val));
  endtask

  task automatic eot(input int tag);
    send(mk(3, tag, $urandom_range(0, 1023), $urandom));
  endtask

  // mode 0: always ready, 1: ready pattern 1-0-0-1, 2: random ready.
  // Stops after stop_after handshakes when stop_after >= 0.
  task automatic readout(input int mode, input int stop_after);
    int    pat [4] = '{1, 0, 0, 1};
    int    n = 0;
    int    cyc = 0;
    bit    rdy;
    beat_t b;
    obs_spk  = '0;
    in_valid = 1'b1;
    in_pkt   = mk(2, 0, 1, 100);
    while (exp_q.size() > 0 && n != stop_after) begin
      if (cyc > 400) begin
        chk("readout_timeout", cyc, 0);
        break;
      end
      b = exp_q[0];
      chk("in_ready_readout", in_ready, 0);
      chk("out_valid", out_valid, 1);
      chk("out_type", out_type, b.typ);
      if (b.typ == 1) begin
        chk("hdr_ts", out_ts, b.ts);
        chk("hdr_layer", out_layer, b.layer);
      end else if (b.typ == 2) begin
        chk("spk_addr", out_addr, b.addr);
        chk("spk_bit", out_spike, b.spk);
        obs_spk[b.addr] = out_spike;
      end
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4] != 0 : 1'($urandom % 2);
      out_ready = rdy;
      @(posedge clk); #1;
      if (rdy) begin
        void'(exp_q.pop_front());
        n++;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (stop_after < 0) begin
      chk("in_ready_after", in_ready, 1);
      chk("out_valid_after", out_valid, 0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_type", out_type, 0);
    chk("rst_err", err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v, tag;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_type", out_type, 0);
    chk("reset_out_ts", out_ts, 0);
    chk("reset_out_layer", out_layer, 0);
    chk("reset_out_addr", out_addr, 0);
    chk("reset_out_spike", out_spike, 0);
    chk("reset_err", err, 0);

    // Idle after reset
    repeat (20) begin
      @(posedge clk); #1;
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_err", err, 0);
    end

    // First timestep of a layer
    psum(4, 40); psum(4, 30); psum(0, 63);
    eot(1);
    readout(0, -1);
    chk("s2_spike_map", obs_spk, 9'b000010000);
    chk("s2_err", err, 0);

    // Last timestep: residue decides addr 4, then done
    psum(4, 60);
    eot(2);
    readout(0, -1);
    chk("s3_addr4", obs_spk[4], SOFT ? 1 : 0);

    // Potentials were cleared by done: addr 0 held 63 before
    psum(0, 1);
    eot(1);
    readout(0, -1);
    chk("clear_spike_map", obs_spk, 0);
    eot(2);
    readout(1, -1);

    // Backpressure 1-0-0-1 across a whole layer
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < 12; k++) psum($urandom_range(0, N - 1), $urandom_range(0, 90));
      eot(m_ts);
      readout(1, -1);
    end

    // Timestep tag mismatch: header still carries the counter
    do_reset();
    eot(2);
    chk("tsmis_err", err, 1);
    readout(0, -1);
    eot(2);
    readout(0, -1);
    chk("tsmis_err_sticky", err, 1);

    // Out-of-range neuron address
    do_reset();
    chk("badaddr_err_before", err, 0);
    psum(9, 5);
    chk("badaddr_err", err, 1);
    eot(1);
    readout(2, -1);
    chk("badaddr_err_sticky", err, 1);

    // Saturation at both ends
    do_reset();
    repeat (300) psum(2, 4095);
    psum(2, -4095); psum(2, -4095); psum(2, -4095); psum(2, -4034);
    repeat (300) psum(5, -4096);
    psum(5, 4095); psum(5, 4095); psum(5, 4095); psum(5, 4095); psum(5, 68);
    eot(1);
    readout(0, -1);
    chk("sat_hi_spike", obs_spk[2], 1);
    chk("sat_lo_spike", obs_spk[5], 1);

    // Reset in the middle of a scan
    psum(7, 500);
    eot(2);
    readout(0, 4);
    do_reset();
    eot(1);
    readout(2, -1);
    chk("after_rst_map", obs_spk, 0);
    eot(2);
    readout(2, -1);

    // Randomized traffic
    for (int r = 0; r < 10; r++) begin
      repeat ($urandom_range(5, 30)) begin
        case ($urandom_range(0, 19))
          0:       psum($urandom_range(N, 1023), $urandom_range(0, 100));
          1, 2:    send(mk($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1023), $urandom));
          3, 4:    psum($urandom_range(0, N - 1), ($urandom_range(0, 1) != 0) ? 4095 : -4096);
          default: begin
            v = $urandom_range(0, 200) - 60;
            psum($urandom_range(0, N - 1), v);
          end
        endcase
      end
      tag = ($urandom_range(0, 9) == 0) ? (m_ts ^ 3) : m_ts;
      eot(tag);
      readout(2, -1);
      chk("rand_err", err, m_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
